// File: rtl/commutator_pkg.sv
// Shared constants for the commutator stage: default sample width (FFTsfpw) and a log2 helper for counter widths.
// Optional build macro used by this slice: COMMUTATOR_SYNC_EN (adds in_sync to the bus).
`ifndef FFTsfpw
`define FFTsfpw 16
`endif

package commutator_pkg;

  localparam int NB_DEFAULT = `FFTsfpw;

  // Ceiling log2, usable in constant expressions; log2_ceil(1) == 0.
  function automatic int log2_ceil(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/commutator_if.sv
// Sample-pair bus into and out of a commutator stage.
// With COMMUTATOR_SYNC_EN defined the bus also carries in_sync (frame realign strobe).
interface commutator_if #(
  parameter int nb = commutator_pkg::NB_DEFAULT
);
  logic                 in_valid;
  logic signed [nb-1:0] in_a;
  logic signed [nb-1:0] in_b;
`ifdef COMMUTATOR_SYNC_EN
  logic                 in_sync;
`endif
  logic                 out_valid;
  logic signed [nb-1:0] out_a;
  logic signed [nb-1:0] out_b;

`ifdef COMMUTATOR_SYNC_EN
  modport master (output in_valid, in_a, in_b, in_sync,
                  input  out_valid, out_a, out_b);
  modport slave  (input  in_valid, in_a, in_b, in_sync,
                  output out_valid, out_a, out_b);
`else
  modport master (output in_valid, in_a, in_b,
                  input  out_valid, out_a, out_b);
  modport slave  (input  in_valid, in_a, in_b,
                  output out_valid, out_a, out_b);
`endif

endinterface

// File: rtl/commutator_delay.sv
// Enable-gated, asynchronously cleared shift register of depth stages; q is d from depth enabled cycles ago.
module commutator_delay #(
  parameter int nb    = 16,
  parameter int depth = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic signed [nb-1:0] d,
  output logic signed [nb-1:0] q
);

  logic signed [nb-1:0] sr_p0 [depth];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) sr_p0[i] <= '0;
    end else if (en) begin
      sr_p0[0] <= d;
      for (int i = 1; i < depth; i++) sr_p0[i] <= sr_p0[i-1];
    end
  end

  assign q = sr_p0[depth-1];

endmodule

// File: rtl/commutator.sv
// Radix-2 delay-commutator: delay upper path by depth beats, swap paths every depth beats, delay lower path.
// Optional COMMUTATOR_SYNC_EN: a beat with in_sync=1 restarts the frame count at 0.
module commutator
  import commutator_pkg::*;
#(
  parameter int nb    = NB_DEFAULT,
  parameter int depth = 4
) (
  input  logic        clk,
  input  logic        rst,
  commutator_if.slave bus
);

  localparam int             CW      = log2_ceil(depth) + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(depth);

  logic                 beat;
  logic [CW-1:0]        cnt_p0;
  logic [CW-1:0]        cnt_eff;
  logic [CW-1:0]        prime_p0;
  logic                 phase;
  logic signed [nb-1:0] p_p0;
  logic signed [nb-1:0] q_p0;
  logic signed [nb-1:0] to_out_a;
  logic signed [nb-1:0] to_dly;
  logic                 vld_p1;
  logic signed [nb-1:0] out_a_p1;
  logic signed [nb-1:0] out_b_p1;

  assign beat = bus.in_valid;

`ifdef COMMUTATOR_SYNC_EN
  assign cnt_eff = bus.in_sync ? '0 : cnt_p0;
`else
  assign cnt_eff = cnt_p0;
`endif

  assign phase = cnt_eff[CW-1];

  // Stage p0: frame counter and priming counter; 2*depth == 2**CW so the add wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p0   <= '0;
      prime_p0 <= '0;
    end else if (beat) begin
      cnt_p0 <= cnt_eff + 1'b1;
      if (prime_p0 != DEPTH_C) prime_p0 <= prime_p0 + 1'b1;
    end
  end

  commutator_delay #(.nb(nb), .depth(depth)) u_dly_p (
    .clk (clk),
    .rst (rst),
    .en  (beat),
    .d   (bus.in_a),
    .q   (p_p0)
  );

  always_comb begin
    to_out_a = p_p0;
    to_dly   = bus.in_b;
    if (phase) begin
      to_out_a = bus.in_b;
      to_dly   = p_p0;
    end
  end

  commutator_delay #(.nb(nb), .depth(depth)) u_dly_q (
    .clk (clk),
    .rst (rst),
    .en  (beat),
    .d   (to_dly),
    .q   (q_p0)
  );

  // Stage p1: output register, loaded only on beats so gaps hold the last pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      out_a_p1 <= '0;
      out_b_p1 <= '0;
    end else begin
      vld_p1 <= beat && (prime_p0 == DEPTH_C);
      if (beat) begin
        out_a_p1 <= to_out_a;
        out_b_p1 <= q_p0;
      end
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_a     = out_a_p1;
  assign bus.out_b     = out_b_p1;

endmodule

// File: tb/tb_commutator.sv
// Scoreboard bench for commutator at depth 2, 1 and 4, with a closed-form model of the commutated pairs.
module tb_commutator;

  localparam int NB = 16;

  typedef struct packed {
    logic [NB-1:0] a;
    logic [NB-1:0] b;
  } pair_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  commutator_if #(.nb(NB)) if2 ();
  commutator_if #(.nb(NB)) if1 ();
  commutator_if #(.nb(NB)) if4 ();

  commutator #(.nb(NB), .depth(2)) u_d2 (.clk(clk), .rst(rst), .bus(if2.slave));
  commutator #(.nb(NB), .depth(1)) u_d1 (.clk(clk), .rst(rst), .bus(if1.slave));
  commutator #(.nb(NB), .depth(4)) u_d4 (.clk(clk), .rst(rst), .bus(if4.slave));

  int            cur;
  int            cur_d;
  logic          vld;
  logic [NB-1:0] da;
  logic [NB-1:0] db;

  assign if2.in_valid = vld && (cur == 0);
  assign if1.in_valid = vld && (cur == 1);
  assign if4.in_valid = vld && (cur == 2);
  assign if2.in_a = da;
  assign if2.in_b = db;
  assign if1.in_a = da;
  assign if1.in_b = db;
  assign if4.in_a = da;
  assign if4.in_b = db;

`ifdef COMMUTATOR_SYNC_EN
  logic sync;
  assign if2.in_sync = sync && (cur == 0);
  assign if1.in_sync = 1'b0;
  assign if4.in_sync = 1'b0;
`endif

  logic          obs_v;
  logic [NB-1:0] obs_a;
  logic [NB-1:0] obs_b;

  always_comb begin
    obs_v = if2.out_valid;
    obs_a = if2.out_a;
    obs_b = if2.out_b;
    if (cur == 1) begin
      obs_v = if1.out_valid;
      obs_a = if1.out_a;
      obs_b = if1.out_b;
    end else if (cur == 2) begin
      obs_v = if4.out_valid;
      obs_a = if4.out_a;
      obs_b = if4.out_b;
    end
  end

  int            n_assert = 0;
  int            n_fail   = 0;
  logic [NB-1:0] ha [$];
  logic [NB-1:0] hb [$];
  pair_t         sb_q [$];
  pair_t         tbl_q [$];
  bit            tbl_mode = 1'b0;
  bit            hold_ok  = 1'b0;
  pair_t         hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Beat n (n >= d): phase = floor(n/d) mod 2.
  // Phase 1 pairs (b[n], b[n-d]); phase 0 pairs (a[n-d], a[n-2d]).
  function automatic pair_t model(input int n, input int d);
    pair_t r;
    if (((n / d) % 2) == 1) begin
      r.a = hb[n];
      r.b = hb[n-d];
    end else begin
      r.a = ha[n-d];
      r.b = ha[n-2*d];
    end
    return r;
  endfunction

  task automatic start(input int c, input int d);
    cur   = c;
    cur_d = d;
    ha.delete();
    hb.delete();
    sb_q.delete();
    hold_ok = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input logic v, input logic [NB-1:0] a, input logic [NB-1:0] b);
    int    n;
    logic  ev;
    pair_t e;
    vld = v;
    da  = a;
    db  = b;
    ev  = 1'b0;
    if (v) begin
      n = ha.size();
      ha.push_back(a);
      hb.push_back(b);
      if (n >= cur_d) begin
        ev = 1'b1;
        if (tbl_mode) begin
          if (tbl_q.size() > 0) e = tbl_q.pop_front();
          else e = '0;
        end else begin
          e = model(n, cur_d);
        end
        sb_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    chk($sformatf("out_valid d%0d beat%0d", cur_d, ha.size() - 1), {31'd0, obs_v}, {31'd0, ev});
    if (ev) begin
      e = sb_q.pop_front();
      chk($sformatf("out_a d%0d beat%0d", cur_d, ha.size() - 1), {16'd0, obs_a}, {16'd0, e.a});
      chk($sformatf("out_b d%0d beat%0d", cur_d, ha.size() - 1), {16'd0, obs_b}, {16'd0, e.b});
      hold    = e;
      hold_ok = 1'b1;
    end else if (v) begin
      hold_ok = 1'b0;
    end else if (hold_ok) begin
      chk("hold_a", {16'd0, obs_a}, {16'd0, hold.a});
      chk("hold_b", {16'd0, obs_b}, {16'd0, hold.b});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    vld = 1'b0;
    da  = '0;
    db  = '0;
    cur = 0;
    cur_d = 2;
`ifdef COMMUTATOR_SYNC_EN
    sync = 1'b0;
`endif

    #3;
    chk("rst d2 out_valid", {31'd0, if2.out_valid}, 32'd0);
    chk("rst d2 out_a", {16'd0, if2.out_a}, 32'd0);
    chk("rst d2 out_b", {16'd0, if2.out_b}, 32'd0);
    chk("rst d1 out_valid", {31'd0, if1.out_valid}, 32'd0);
    chk("rst d1 out_a", {16'd0, if1.out_a}, 32'd0);
    chk("rst d1 out_b", {16'd0, if1.out_b}, 32'd0);
    chk("rst d4 out_valid", {31'd0, if4.out_valid}, 32'd0);
    chk("rst d4 out_a", {16'd0, if4.out_a}, 32'd0);
    chk("rst d4 out_b", {16'd0, if4.out_b}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // D=2 continuous beats
    start(0, 2);
    for (int n = 0; n < 8; n++) step(1'b1, 16'h0100 + 16'(n), 16'h0200 + 16'(n));

    // D=2 with a 3-cycle gap after beat 4
    do_reset();
    start(0, 2);
    for (int n = 0; n < 5; n++) step(1'b1, 16'h0100 + 16'(n), 16'h0200 + 16'(n));
    for (int g = 0; g < 3; g++) step(1'b0, 16'hdead, 16'hbeef);
    for (int n = 5; n < 8; n++) step(1'b1, 16'h0100 + 16'(n), 16'h0200 + 16'(n));

    // D=1 continuous beats
    do_reset();
    start(1, 1);
    for (int n = 0; n < 4; n++) step(1'b1, 16'h0100 + 16'(n), 16'h0200 + 16'(n));

    // D=2 asynchronous reset mid-frame after beat 5, then restart
    do_reset();
    start(0, 2);
    for (int n = 0; n < 6; n++) step(1'b1, 16'h0100 + 16'(n), 16'h0200 + 16'(n));
    #2 rst = 1'b1;
    #1;
    chk("async rst out_valid", {31'd0, if2.out_valid}, 32'd0);
    chk("async rst out_a", {16'd0, if2.out_a}, 32'd0);
    chk("async rst out_b", {16'd0, if2.out_b}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    start(0, 2);
    for (int n = 0; n < 8; n++) step(1'b1, 16'h0100 + 16'(n), 16'h0200 + 16'(n));

    // D=4, 64 random beats with occasional idle cycles
    do_reset();
    start(2, 4);
    for (int n = 0; n < 64; n++) begin
      if ($urandom_range(0, 3) == 0) step(1'b0, 16'($urandom), 16'($urandom));
      step(1'b1, 16'($urandom), 16'($urandom));
    end

`ifdef COMMUTATOR_SYNC_EN
    // D=2, in_sync on beat 3 realigns the frame to phase 0
    do_reset();
    start(0, 2);
    tbl_q.delete();
    tbl_q.push_back('{a: 16'h0202, b: 16'h0200});
    tbl_q.push_back('{a: 16'h0101, b: 16'h0201});
    tbl_q.push_back('{a: 16'h0102, b: 16'h0100});
    tbl_q.push_back('{a: 16'h0205, b: 16'h0203});
    tbl_q.push_back('{a: 16'h0206, b: 16'h0204});
    tbl_q.push_back('{a: 16'h0105, b: 16'h0103});
    tbl_mode = 1'b1;
    for (int n = 0; n < 8; n++) begin
      sync = (n == 3);
      step(1'b1, 16'h0100 + 16'(n), 16'h0200 + 16'(n));
    end
    sync     = 1'b0;
    tbl_mode = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
